font_rom_arbiter: RTL and testbench

Shares the single font glyph ROM between the two text requesters: start-screen Pokémon name rendering and battle-info text rendering. Each requester presents a glyph code, glyph row and bit index. The block arbitrates, issues one ROM read per cycle through a registered two-stage pipeline, and returns the glyph row and selected pixel bit to the granted requester. The colour palette consumes the returned pixel bit in place of a direct ROM lookup.

---
 rtl/font_rom_arbiter_pkg.sv | 33 +++
 rtl/font_rom_arbiter_if.sv | 39 +++
 rtl/font_rom_arbiter_rom_sync.sv | 35 +++
 rtl/font_rom_arbiter.sv | 130 +++++++++++++
 tb/tb_font_rom_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/font_rom_arbiter_pkg.sv
// Purpose: shared types and constants for the font ROM arbiter slice.
// Latency: n/a (types, constants and the address helper only).
// Backpressure: n/a.
// Contents: GLYPH_ROWS, ADDR_W, font_req_t owner tag, font_s1_t stage-1 payload,
// glyph_addr() address helper.
package font_arb_pkg;

    localparam int GLYPH_ROWS = 16;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 8;

    // Owner tag carried alongside each read so the response can be steered.
    typedef enum logic {
        REQ_START  = 1'b0,
        REQ_BATTLE = 1'b1
    } font_req_t;

    // Stage-1 payload: ROM address, pixel column to pick, and owner tag.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        bit_idx;
        font_req_t         tag;
    } font_s1_t;

    // row + GLYPH_ROWS * hex, truncated to ADDR_W; out-of-range codes wrap silently.
    function automatic logic [ADDR_W-1:0] glyph_addr(input logic [7:0] hex,
                                                     input logic [3:0] row);
        logic [ADDR_W+7:0] full;
        full = (ADDR_W+8)'(hex) * (ADDR_W+8)'(GLYPH_ROWS) + (ADDR_W+8)'(row);
        return full[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/font_rom_arbiter_if.sv
// Purpose: request/response bundle between the two text requesters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests held until granted; responses cannot be stalled.
// Ports: req/hex/row/bit per requester, combinational gnt per requester,
// rvalid per requester, shared rdata/rpix response bus.
interface font_arb_if;

    logic       req_s;
    logic [7:0] hex_s;
    logic [3:0] row_s;
    logic [2:0] bit_s;

    logic       req_b;
    logic [7:0] hex_b;
    logic [3:0] row_b;
    logic [2:0] bit_b;

    logic       gnt_s;
    logic       gnt_b;
    logic       rvalid_s;
    logic       rvalid_b;
    logic [7:0] rdata;
    logic       rpix;

    // Requester side (the text renderers).
    modport master (
        output req_s, hex_s, row_s, bit_s,
        output req_b, hex_b, row_b, bit_b,
        input  gnt_s, gnt_b, rvalid_s, rvalid_b, rdata, rpix
    );

    // Arbiter side.
    modport slave (
        input  req_s, hex_s, row_s, bit_s,
        input  req_b, hex_b, row_b, bit_b,
        output gnt_s, gnt_b, rvalid_s, rvalid_b, rdata, rpix
    );

endinterface

// File: rtl/font_rom_arbiter_rom_sync.sv
// Purpose: registered-output glyph ROM, 2^ADDR_W x 8.
// Latency: 1 cycle from address (with i_en) to o_data.
// Backpressure: none; o_data holds while i_en is low.
// Ports: Clk, Reset_n, i_en (read strobe), i_addr, o_data (registered, 0 after reset).
module font_rom_sync
    import font_arb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_word;

    // Glyph table contents: low address byte plus the upper address bits
    // shifted into the top of the byte. Every row of every code is distinct
    // enough to catch addressing errors downstream.
    always_comb begin
        w_word = i_addr[7:0] + {i_addr[ADDR_W-1:8], 5'b00000};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_word;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/font_rom_arbiter.sv
// Purpose: shares the glyph ROM between start-screen and battle-info text renderers.
// Latency: accept edge N -> rvalid for that request after edge N+1 (2 register stages).
// Backpressure: combinational gnt per requester; one accept per cycle, responses never stall.
// Ports: Clk, Reset_n (async active-low), bus (font_arb_if.slave).
// Build option: FONT_ARB_FIXED_PRIO_EN selects fixed priority (battle wins ties);
// undefined selects round-robin on last_b.
module font_rom_arbiter
    import font_arb_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    font_arb_if.slave  bus
);

    logic              w_gnt_s;
    logic              w_gnt_b;
    logic              w_accept;
    font_s1_t          w_s1_nxt;

    font_s1_t          r_s1;
    logic              r_v1;
    logic              r_v2;
    logic [2:0]        r_bit2;
    font_req_t         r_tag2;
    logic [DATA_W-1:0] w_rom_data;

    // ------------------------------------------------------------------
    // Arbitration: purely from req_* and last_b, never from the ROM side.
    // ------------------------------------------------------------------
`ifdef FONT_ARB_FIXED_PRIO_EN
    // Battle info always wins; start screen only gets idle battle cycles.
    assign w_gnt_b = bus.req_b;
    assign w_gnt_s = bus.req_s & ~bus.req_b;
`else
    logic r_last_b;

    always_comb begin
        w_gnt_s = 1'b0;
        w_gnt_b = 1'b0;
        if (bus.req_s && bus.req_b) begin
            // Tie: whoever was not granted last goes now.
            if (r_last_b) begin
                w_gnt_s = 1'b1;
            end else begin
                w_gnt_b = 1'b1;
            end
        end else begin
            w_gnt_s = bus.req_s;
            w_gnt_b = bus.req_b;
        end
    end

    // Reset to 1 so the start screen wins the very first tie.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last_b <= 1'b1;
        end else if (w_accept) begin
            r_last_b <= w_gnt_b;
        end
    end
`endif

    assign w_accept  = w_gnt_s | w_gnt_b;
    assign bus.gnt_s = w_gnt_s;
    assign bus.gnt_b = w_gnt_b;

    // ------------------------------------------------------------------
    // Stage 0 -> 1: capture the winner's address, column and tag.
    // ------------------------------------------------------------------
    always_comb begin
        w_s1_nxt = '0;
        if (w_gnt_b) begin
            w_s1_nxt.addr    = glyph_addr(bus.hex_b, bus.row_b);
            w_s1_nxt.bit_idx = bus.bit_b;
            w_s1_nxt.tag     = REQ_BATTLE;
        end else begin
            w_s1_nxt.addr    = glyph_addr(bus.hex_s, bus.row_s);
            w_s1_nxt.bit_idx = bus.bit_s;
            w_s1_nxt.tag     = REQ_START;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_s1 <= w_s1_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 -> 2: ROM read. The ROM's own output register is the
    // stage-2 data register; column and tag ride alongside it.
    // ------------------------------------------------------------------
    font_rom_sync u_rom (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_en    (r_v1),
        .i_addr  (r_s1.addr),
        .o_data  (w_rom_data)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_v2   <= 1'b0;
            r_bit2 <= '0;
            r_tag2 <= REQ_START;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_bit2 <= r_s1.bit_idx;
                r_tag2 <= r_s1.tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response steering. rpix is a mux of two stage-2 registers, so it is
    // aligned with rdata; column 0 is the MSB of the glyph row.
    // ------------------------------------------------------------------
    assign bus.rvalid_s = r_v2 && (r_tag2 == REQ_START);
    assign bus.rvalid_b = r_v2 && (r_tag2 == REQ_BATTLE);
    assign bus.rdata    = w_rom_data;
    assign bus.rpix     = w_rom_data[3'd7 - r_bit2];

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Purpose: self-checking bench for font_rom_arbiter (directed vectors + corner sequences).
// Latency: expects rvalid two negedges after the accepting cycle's drive.
// Backpressure: drives requests only; responses are sampled every cycle.
module tb_font_rom_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    font_arb_if bus ();

    font_rom_arbiter u_dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       req_s;
        logic [7:0] hex_s;
        logic [3:0] row_s;
        logic [2:0] bit_s;
        logic       req_b;
        logic [7:0] hex_b;
        logic [3:0] row_b;
        logic [2:0] bit_b;
        logic [7:0] exp_rdata;
        logic       exp_rpix;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_s = 1'b0; bus.hex_s = 8'h00; bus.row_s = 4'h0; bus.bit_s = 3'd0;
        bus.req_b = 1'b0; bus.hex_b = 8'h00; bus.row_b = 4'h0; bus.bit_b = 3'd0;
    endtask

    // Watchdog: the bench must end on its own even if something stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        total = 0;
        bad   = 0;

        // Single-request vectors; rdata/rpix hand-computed from the glyph table
        // (word = addr[7:0] + addr[10:8]*32, addr = hex*16 + row mod 2048).
        vecs[0] = '{"s_41_5",   1, 8'h41, 4'd5,  3'd2, 0, 8'h00, 4'd0,  3'd0, 8'h95, 1'b0};
        vecs[1] = '{"b_20_3",   0, 8'h00, 4'd0,  3'd0, 1, 8'h20, 4'd3,  3'd0, 8'h43, 1'b0};
        vecs[2] = '{"s_7f_15",  1, 8'h7F, 4'd15, 3'd7, 0, 8'h00, 4'd0,  3'd0, 8'hDF, 1'b1};
        vecs[3] = '{"b_ff_15",  0, 8'h00, 4'd0,  3'd0, 1, 8'hFF, 4'd15, 3'd1, 8'hDF, 1'b1};
        vecs[4] = '{"s_80_wrap",1, 8'h80, 4'd0,  3'd3, 0, 8'h00, 4'd0,  3'd0, 8'h00, 1'b0};
        vecs[5] = '{"b_12_9",   0, 8'h00, 4'd0,  3'd0, 1, 8'h12, 4'd9,  3'd5, 8'h49, 1'b0};
        vecs[6] = '{"s_3a_6",   1, 8'h3A, 4'd6,  3'd5, 0, 8'h00, 4'd0,  3'd0, 8'h06, 1'b1};

        // ---------------- Reset state ----------------
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rvalid_s", 16'(bus.rvalid_s), 16'd0);
        chk("rst_rvalid_b", 16'(bus.rvalid_b), 16'd0);
        chk("rst_rdata",    16'(bus.rdata),    16'h00);
        chk("rst_rpix",     16'(bus.rpix),     16'd0);

        // ---------------- Release with both requesting; alternation ----------------
        rst_n = 1'b1;
        bus.hex_s = 8'h41; bus.row_s = 4'd5; bus.bit_s = 3'd2;
        bus.hex_b = 8'h20; bus.row_b = 4'd3; bus.bit_b = 3'd0;
        for (int k = 0; k < 6; k++) begin
            logic eg_s, eg_b, ev_s, ev_b;
            if (k > 0) @(negedge clk);
            bus.req_s = (k < 4);
            bus.req_b = (k < 4);
            #1;
`ifdef FONT_ARB_FIXED_PRIO_EN
            eg_s = 1'b0;
            eg_b = (k < 4);
            ev_s = 1'b0;
            ev_b = (k >= 2);
`else
            eg_s = (k < 4) && (k % 2 == 0);
            eg_b = (k < 4) && (k % 2 == 1);
            ev_s = (k >= 2) && (k % 2 == 0);
            ev_b = (k >= 2) && (k % 2 == 1);
`endif
            chk($sformatf("alt_gnt_s[%0d]", k), 16'(bus.gnt_s), 16'(eg_s));
            chk($sformatf("alt_gnt_b[%0d]", k), 16'(bus.gnt_b), 16'(eg_b));
            chk($sformatf("alt_rvalid_s[%0d]", k), 16'(bus.rvalid_s), 16'(ev_s));
            chk($sformatf("alt_rvalid_b[%0d]", k), 16'(bus.rvalid_b), 16'(ev_b));
            if (ev_s) chk($sformatf("alt_rdata_s[%0d]", k), 16'(bus.rdata), 16'h95);
            if (ev_b) chk($sformatf("alt_rdata_b[%0d]", k), 16'(bus.rdata), 16'h43);
            @(posedge clk);
        end
        @(negedge clk);
        chk("alt_drain_s", 16'(bus.rvalid_s), 16'd0);
        chk("alt_drain_b", 16'(bus.rvalid_b), 16'd0);

        // ---------------- Table-driven single transactions ----------------
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            bus.req_s = vecs[i].req_s; bus.hex_s = vecs[i].hex_s;
            bus.row_s = vecs[i].row_s; bus.bit_s = vecs[i].bit_s;
            bus.req_b = vecs[i].req_b; bus.hex_b = vecs[i].hex_b;
            bus.row_b = vecs[i].row_b; bus.bit_b = vecs[i].bit_b;
            #1;
            chk({vecs[i].name, "_gnt_s"}, 16'(bus.gnt_s), 16'(vecs[i].req_s));
            chk({vecs[i].name, "_gnt_b"}, 16'(bus.gnt_b), 16'(vecs[i].req_b));
            @(posedge clk);
            @(negedge clk);
            idle_inputs();
            chk({vecs[i].name, "_early_s"}, 16'(bus.rvalid_s), 16'd0);
            chk({vecs[i].name, "_early_b"}, 16'(bus.rvalid_b), 16'd0);
            @(negedge clk);
            chk({vecs[i].name, "_rvalid_s"}, 16'(bus.rvalid_s), 16'(vecs[i].req_s));
            chk({vecs[i].name, "_rvalid_b"}, 16'(bus.rvalid_b), 16'(vecs[i].req_b));
            chk({vecs[i].name, "_rdata"},    16'(bus.rdata),    16'(vecs[i].exp_rdata));
            chk({vecs[i].name, "_rpix"},     16'(bus.rpix),     16'(vecs[i].exp_rpix));
        end
        @(negedge clk);
        chk("tbl_pulse_s", 16'(bus.rvalid_s), 16'd0);
        chk("tbl_pulse_b", 16'(bus.rvalid_b), 16'd0);

        // ---------------- Starvation: req_b held, req_s asserted ----------------
        bus.req_b = 1'b1; bus.hex_b = 8'h01;
        bus.req_s = 1'b1; bus.hex_s = 8'h02;
        seen = -1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("starve_excl[%0d]", c), 16'(bus.gnt_s & bus.gnt_b), 16'd0);
`ifdef FONT_ARB_FIXED_PRIO_EN
            chk($sformatf("starve_gnt_s[%0d]", c), 16'(bus.gnt_s), 16'd0);
            chk($sformatf("starve_gnt_b[%0d]", c), 16'(bus.gnt_b), 16'd1);
`else
            if (bus.gnt_s && seen < 0) seen = c;
`endif
            @(posedge clk);
            @(negedge clk);
        end
`ifndef FONT_ARB_FIXED_PRIO_EN
        chk("starve_s_granted", 16'(seen >= 0), 16'd1);
        chk("starve_s_within2", 16'(seen >= 0 && seen < 2), 16'd1);
`endif
        idle_inputs();
        repeat (3) @(negedge clk);

        // ---------------- Reset discards in-flight reads ----------------
        bus.req_s = 1'b1; bus.hex_s = 8'h41; bus.row_s = 4'd5;
        @(posedge clk);
        @(negedge clk);
        bus.req_s = 1'b0;
        bus.req_b = 1'b1; bus.hex_b = 8'h20; bus.row_b = 4'd3;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        idle_inputs();
        chk("flush_rst_rvalid_s", 16'(bus.rvalid_s), 16'd0);
        chk("flush_rst_rvalid_b", 16'(bus.rvalid_b), 16'd0);
        chk("flush_rst_rdata",    16'(bus.rdata),    16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("flush_rvalid[%0d]", c), 16'(bus.rvalid_s | bus.rvalid_b), 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
